network_div_div_30s_14s_16_seq: RTL

//  Multi-cycle signed divider; the inverse of the 16s x 14s -> 30s MAC multiplier.

---
 rtl/network_div_div_30s_14s_16_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/network_div_div_30s_14s_16_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// network_div_div_30s_14s_16_seq
//   Multi-cycle signed divider (inverse of the 16s x 14s -> 30s MAC multiply).
//   Divides a 30-bit signed accumulator by a 14-bit signed scale/count and
//   returns a saturated 16-bit signed quotient truncated toward zero, plus a
//   remainder carrying the dividend's sign. Radix-2 restoring division on
//   magnitudes, one quotient bit per cycle, one operation in flight.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (0 = reset)
//   ce           clock enable; 0 freezes all state and blocks handshakes
//   in_valid     din0/din1 valid            in_ready     divider idle
//   din0         signed dividend            din1         signed divisor
//   out_valid    result valid (held)        out_ready    consumer accepts
//   dout         saturated signed quotient  rem          signed remainder
//   ovf          quotient saturated         div_by_zero  divisor was zero
// ---------------------------------------------------------------------------
module network_div_div_30s_14s_16_seq #(
    parameter int unsigned DIVIDEND_WIDTH = 30,
    parameter int unsigned DIVISOR_WIDTH  = 14,
    parameter int unsigned QUOTIENT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QUOTIENT_WIDTH-1:0] dout,
    output logic [DIVISOR_WIDTH-1:0]  rem,
    output logic                      ovf,
    output logic                      div_by_zero
);

    localparam int unsigned DW   = DIVIDEND_WIDTH;
    localparam int unsigned VW   = DIVISOR_WIDTH;
    localparam int unsigned QW   = QUOTIENT_WIDTH;
    localparam int unsigned CntW = $clog2(DW);

    localparam logic [CntW-1:0] CntInit = CntW'(DW - 1);
    // Largest quotient magnitudes representable for negative / positive results.
    localparam logic [DW-1:0]   NegLim  = DW'(2 ** (QW - 1));
    localparam logic [DW-1:0]   PosLim  = NegLim - DW'(1);
    localparam logic [QW-1:0]   QMax    = {1'b0, {(QW - 1){1'b1}}};
    localparam logic [QW-1:0]   QMin    = {1'b1, {(QW - 1){1'b0}}};
    localparam logic [QW-1:0]   QOne    = QW'(1);
    localparam logic [VW-1:0]   ROne    = VW'(1);
    localparam logic [DW-1:0]   DOne    = DW'(1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [DW-1:0]   quo_q;      // dividend magnitude shifting out, quotient shifting in
    logic [VW-1:0]   prem_q;     // partial remainder, always < divisor magnitude
    logic [VW-1:0]   dvs_q;      // divisor magnitude
    logic            sign0_q;
    logic            sign1_q;
    logic            dbz_q;
    logic            zin_q;
    logic            out_valid_q;
    logic [QW-1:0]   dout_q;
    logic [VW-1:0]   rem_q;
    logic            ovf_q;
    logic            dbz_out_q;

    // Operand magnitudes; the most negative values map to 2^(W-1) unsigned.
    logic [DW-1:0] abs0;
    logic [VW-1:0] abs1;
    always_comb begin
        abs0 = din0[DW-1] ? (~din0 + DOne) : din0;
        abs1 = din1[VW-1] ? (~din1 + ROne) : din1;
    end

    // One restoring-division step. The shifted remainder needs VW+1 bits; the
    // difference always fits in VW bits because it is below the divisor.
    logic [VW:0]   shift_rem;
    logic          fits;
    logic [VW-1:0] step_rem_d;
    logic [DW-1:0] step_quo_d;
    always_comb begin
        shift_rem  = {prem_q, quo_q[DW-1]};
        fits       = (shift_rem >= {1'b0, dvs_q});
        step_rem_d = fits ? (shift_rem[VW-1:0] - dvs_q) : shift_rem[VW-1:0];
        step_quo_d = {quo_q[DW-2:0], fits};
    end

    // Sign fix-up and saturation of the final magnitudes.
    logic          q_neg;
    logic          sat;
    logic [QW-1:0] q_val;
    logic [QW-1:0] fix_dout_d;
    logic [VW-1:0] fix_rem_d;
    logic          fix_ovf_d;
    always_comb begin
        q_neg      = sign0_q ^ sign1_q;
        sat        = q_neg ? (quo_q > NegLim) : (quo_q > PosLim);
        q_val      = q_neg ? (~quo_q[QW-1:0] + QOne) : quo_q[QW-1:0];
        fix_dout_d = '0;
        fix_rem_d  = '0;
        fix_ovf_d  = 1'b0;
        if (dbz_q) begin
            fix_dout_d = sign0_q ? QMin : QMax;
            fix_ovf_d  = 1'b1;
        end else if (!zin_q) begin
            fix_ovf_d  = sat;
            fix_dout_d = sat ? (q_neg ? QMin : QMax) : q_val;
            fix_rem_d  = sign0_q ? (~prem_q + ROne) : prem_q;
        end
    end

    assign in_ready    = (state_q == StIdle) & ce & reset;
    assign out_valid   = out_valid_q;
    assign dout        = dout_q;
    assign rem         = rem_q;
    assign ovf         = ovf_q;
    assign div_by_zero = dbz_out_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            quo_q       <= '0;
            prem_q      <= '0;
            dvs_q       <= '0;
            sign0_q     <= 1'b0;
            sign1_q     <= 1'b0;
            dbz_q       <= 1'b0;
            zin_q       <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            rem_q       <= '0;
            ovf_q       <= 1'b0;
            dbz_out_q   <= 1'b0;
        end else if (ce) begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sign0_q <= din0[DW-1];
                        sign1_q <= din1[VW-1];
                        quo_q   <= abs0;
                        dvs_q   <= abs1;
                        prem_q  <= '0;
                        dbz_q   <= (din1 == '0);
                        zin_q   <= (din0 == '0);
                        cnt_q   <= CntInit;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    prem_q <= step_rem_d;
                    quo_q  <= step_quo_d;
                    if (cnt_q == '0) begin
                        state_q <= StFix;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StFix: begin
                    dout_q      <= fix_dout_d;
                    rem_q       <= fix_rem_d;
                    ovf_q       <= fix_ovf_d;
                    dbz_out_q   <= dbz_q;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
